// File: rtl/conv_subblock_reader_pkg.sv
// Shared constants for the conv-encoder subblock drain: block sizes,
// FSM state encoding and the out_sel source codes.
package conv_subblock_reader_pkg;

  localparam int SHORT_BYTES_DEF = 132;
  localparam int LONG_BYTES_DEF  = 768;
  localparam int CNT_W_DEF       = 10;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_CAP  = 3'd2,
    ST_S0   = 3'd3,
    ST_S1   = 3'd4,
    ST_S2   = 3'd5,
    ST_FIN  = 3'd6
  } state_t;

  localparam logic [1:0] SEL_Q0 = 2'd0;
  localparam logic [1:0] SEL_Q1 = 2'd1;
  localparam logic [1:0] SEL_Q2 = 2'd2;

endpackage

// File: rtl/conv_subblock_reader.sv
// Drains the three subblock FIFOs of the rate-1/3 encoder one triplet at a
// time and serialises them as q0,q1,q2,... over a valid/ready byte stream.
module conv_subblock_reader
  import conv_subblock_reader_pkg::*;
#(
  parameter int SHORT_BYTES = SHORT_BYTES_DEF,
  parameter int LONG_BYTES  = LONG_BYTES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       computation_done,
  input  logic       length_out,
  input  logic [7:0] q0,
  input  logic [7:0] q1,
  input  logic [7:0] q2,
  output logic       rdreq_subblock,
  output logic [7:0] out_data,
  output logic [1:0] out_sel,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       busy,
  output logic       block_done,
  output logic       overrun
);

  state_t             r_state;
  state_t             w_next;
  logic               r_done_d;
  logic               r_busy;
  logic               r_overrun;
  logic [CNT_W-1:0]   r_idx;
  logic [CNT_W-1:0]   r_nm1;
  logic [7:0]         r_h0;
  logic [7:0]         r_h1;
  logic [7:0]         r_h2;

  logic               w_rise;
  logic               w_start;
  logic               w_is_last;

  assign w_rise    = computation_done & ~r_done_d;
  assign w_start   = w_rise & (r_state == ST_IDLE);
  assign w_is_last = (r_idx == r_nm1);

  assign busy    = r_busy;
  assign overrun = r_overrun;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Datapath: start latch, triplet capture, index advance and status flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_done_d  <= 1'b0;
      r_busy    <= 1'b0;
      r_overrun <= 1'b0;
      r_idx     <= '0;
      r_nm1     <= '0;
      r_h0      <= '0;
      r_h1      <= '0;
      r_h2      <= '0;
    end else begin
      r_done_d <= computation_done;
      if (w_start) begin
        r_nm1  <= length_out ? CNT_W'(LONG_BYTES - 1) : CNT_W'(SHORT_BYTES - 1);
        r_idx  <= '0;
        r_busy <= 1'b1;
      end
      // FIFO data is valid the cycle after the pop.
      if (r_state == ST_CAP) begin
        r_h0 <= q0;
        r_h1 <= q1;
        r_h2 <= q2;
      end
      if ((r_state == ST_S2) && out_ready) begin
        if (w_is_last) begin
          r_busy <= 1'b0;
        end else begin
          r_idx <= r_idx + 1'b1;
        end
      end
      if (w_rise && r_busy) begin
        r_overrun <= 1'b1;
      end
    end
  end

  always_comb begin
    w_next         = r_state;
    rdreq_subblock = 1'b0;
    out_valid      = 1'b0;
    out_data       = 8'd0;
    out_sel        = SEL_Q0;
    out_last       = 1'b0;
    block_done     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start) w_next = ST_RD;
      end
      ST_RD: begin
        rdreq_subblock = 1'b1;
        w_next         = ST_CAP;
      end
      ST_CAP: begin
        w_next = ST_S0;
      end
      ST_S0: begin
        out_valid = 1'b1;
        out_data  = r_h0;
        out_sel   = SEL_Q0;
        if (out_ready) w_next = ST_S1;
      end
      ST_S1: begin
        out_valid = 1'b1;
        out_data  = r_h1;
        out_sel   = SEL_Q1;
        if (out_ready) w_next = ST_S2;
      end
      ST_S2: begin
        out_valid = 1'b1;
        out_data  = r_h2;
        out_sel   = SEL_Q2;
        out_last  = w_is_last;
        if (out_ready) w_next = w_is_last ? ST_FIN : ST_RD;
      end
      ST_FIN: begin
        block_done = 1'b1;
        w_next     = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_conv_subblock_reader.sv
// Bench for conv_subblock_reader: FIFO model plus an expected byte stream
// built from the FIFO contents, checked on every accepted or stalled byte.
`timescale 1ns/1ps
module tb_conv_subblock_reader;

  logic       clk;
  logic       reset;
  logic       computation_done;
  logic       length_out;
  logic [7:0] q0, q1, q2;
  logic       rdreq_subblock;
  logic [7:0] out_data;
  logic [1:0] out_sel;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       busy;
  logic       block_done;
  logic       overrun;

  conv_subblock_reader dut (
    .clk              (clk),
    .reset            (reset),
    .computation_done (computation_done),
    .length_out       (length_out),
    .q0               (q0),
    .q1               (q1),
    .q2               (q2),
    .rdreq_subblock   (rdreq_subblock),
    .out_data         (out_data),
    .out_sel          (out_sel),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_last         (out_last),
    .busy             (busy),
    .block_done       (block_done),
    .overrun          (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] f0 [768];
  logic [7:0] f1 [768];
  logic [7:0] f2 [768];
  int         f_ptr;
  int         n_blk;

  logic [7:0] exp_data [2304];
  logic [1:0] exp_sel  [2304];
  logic       exp_last [2304];
  logic [7:0] log_data [2304];

  int pos, rd_cnt, bd_cnt, busy_cnt;
  int n_chk, n_pass;
  bit rand_rdy;

  bit         prev_stall;
  logic [7:0] pd;
  logic [1:0] ps;
  logic       pl;

  logic [7:0] lit_head [6] = '{8'h00, 8'h80, 8'h40, 8'h01, 8'h81, 8'h41};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, expv, $time);
  endtask

  // Non-show-ahead FIFO: data appears the cycle after the pop.
  always @(posedge clk) begin
    if (rdreq_subblock) begin
      if (f_ptr < n_blk) begin
        q0 <= f0[f_ptr];
        q1 <= f1[f_ptr];
        q2 <= f2[f_ptr];
      end else begin
        q0 <= 8'hEE;
        q1 <= 8'hEE;
        q2 <= 8'hEE;
      end
      f_ptr = f_ptr + 1;
    end
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (rdreq_subblock) begin
        rd_cnt++;
        chk("rdreq_with_valid", {31'd0, out_valid}, 32'd0);
      end
      if (busy) busy_cnt++;
      if (block_done) bd_cnt++;
      if (prev_stall) begin
        chk("stall_valid", {31'd0, out_valid}, 32'd1);
        chk("stall_data", {24'd0, out_data}, {24'd0, pd});
        chk("stall_sel", {30'd0, out_sel}, {30'd0, ps});
        chk("stall_last", {31'd0, out_last}, {31'd0, pl});
      end
      if (out_valid && out_ready) begin
        if (pos < 3 * n_blk) begin
          chk("byte_data", {24'd0, out_data}, {24'd0, exp_data[pos]});
          chk("byte_sel", {30'd0, out_sel}, {30'd0, exp_sel[pos]});
          chk("byte_last", {31'd0, out_last}, {31'd0, exp_last[pos]});
          log_data[pos] = out_data;
        end else begin
          chk("extra_byte", pos, 3 * n_blk - 1);
        end
        pos++;
      end
      prev_stall = out_valid && !out_ready;
      pd = out_data;
      ps = out_sel;
      pl = out_last;
    end
  end

  task automatic prep(input bit lng, input bit rnd);
    n_blk = lng ? 768 : 132;
    for (int k = 0; k < n_blk; k++) begin
      if (rnd) begin
        f0[k] = 8'($urandom);
        f1[k] = 8'($urandom);
        f2[k] = 8'($urandom);
      end else begin
        f0[k] = 8'(k);
        f1[k] = 8'h80 | 8'(k);
        f2[k] = 8'h40 | 8'(k);
      end
      exp_data[3*k]   = f0[k];
      exp_data[3*k+1] = f1[k];
      exp_data[3*k+2] = f2[k];
      for (int j = 0; j < 3; j++) begin
        exp_sel[3*k+j]  = 2'(j);
        exp_last[3*k+j] = (k == n_blk - 1) && (j == 2);
      end
    end
    f_ptr    = 0;
    pos      = 0;
    rd_cnt   = 0;
    bd_cnt   = 0;
    busy_cnt = 0;
  endtask

  task automatic start(input bit lng, input int hold);
    @(posedge clk);
    #1;
    length_out       = lng;
    computation_done = 1'b1;
    repeat (hold) @(posedge clk);
    #1;
    computation_done = 1'b0;
  endtask

  task automatic wait_block(input int budget);
    int c;
    c = 0;
    while (bd_cnt == 0 && c < budget) begin
      @(posedge clk);
      c++;
    end
    chk("block_done_seen", {31'd0, bd_cnt > 0}, 32'd1);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_rdreq"}, {31'd0, rdreq_subblock}, 32'd0);
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_data"}, {24'd0, out_data}, 32'd0);
    chk({tag, "_sel"}, {30'd0, out_sel}, 32'd0);
    chk({tag, "_last"}, {31'd0, out_last}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_bdone"}, {31'd0, block_done}, 32'd0);
    chk({tag, "_overrun"}, {31'd0, overrun}, 32'd0);
  endtask

  task automatic check_counts(input string tag, input int n);
    chk({tag, "_rdreq_cnt"}, rd_cnt, n);
    chk({tag, "_byte_cnt"}, pos, 3 * n);
    chk({tag, "_bdone_cnt"}, bd_cnt, 1);
    chk({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int c;
    n_chk = 0; n_pass = 0;
    reset = 1'b1; computation_done = 1'b0; length_out = 1'b0;
    rand_rdy = 1'b0; n_blk = 0; f_ptr = 0;
    pos = 0; rd_cnt = 0; bd_cnt = 0; busy_cnt = 0;
    prev_stall = 1'b0; pd = '0; ps = '0; pl = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle("rst");
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_idle("post_rst");

    // Short block, counting pattern, ready tied high.
    prep(1'b0, 1'b0);
    start(1'b0, 1);
    wait_block(1000);
    check_counts("t1", 132);
    chk("t1_busy_cycles", busy_cnt, 660);
    for (int i = 0; i < 6; i++) chk("t1_head", {24'd0, log_data[i]}, {24'd0, lit_head[i]});
    chk("t1_tail", {24'd0, log_data[395]}, 32'h0000_00C3);

    // Long block, random data.
    prep(1'b1, 1'b1);
    start(1'b1, 1);
    wait_block(5000);
    check_counts("t2", 768);
    chk("t2_busy_cycles", busy_cnt, 3840);

    // Random backpressure.
    rand_rdy = 1'b1;
    prep(1'b0, 1'b1);
    start(1'b0, 1);
    wait_block(4000);
    rand_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_counts("t3", 132);

    // Level-high done must not retrigger.
    prep(1'b0, 1'b1);
    start(1'b0, 1000);
    repeat (20) @(posedge clk);
    #1;
    check_counts("t4a", 132);

    // Second done edge mid-block: overrun only.
    prep(1'b0, 1'b1);
    start(1'b0, 1);
    repeat (100) @(posedge clk);
    #1;
    chk("t4b_overrun_before", {31'd0, overrun}, 32'd0);
    computation_done = 1'b1;
    @(posedge clk);
    #1;
    computation_done = 1'b0;
    wait_block(1000);
    check_counts("t4b", 132);
    chk("t4b_overrun_after", {31'd0, overrun}, 32'd1);

    // Reset while idx 50 is in S1, then a fresh block.
    prep(1'b0, 1'b1);
    start(1'b0, 1);
    c = 0;
    while (pos < 151 && c < 1000) begin
      @(posedge clk);
      c++;
    end
    chk("t5_reached_idx50", {31'd0, pos == 151}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check_idle("t5_rst");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    prep(1'b0, 1'b0);
    start(1'b0, 1);
    wait_block(1000);
    check_counts("t5", 132);
    chk("t5_first_byte", {24'd0, log_data[0]}, 32'd0);

    // Back-to-back short then long.
    prep(1'b0, 1'b1);
    start(1'b0, 1);
    wait_block(1000);
    check_counts("t6a", 132);
    prep(1'b1, 1'b1);
    start(1'b1, 1);
    wait_block(5000);
    check_counts("t6b", 768);
    chk("t6_overrun", {31'd0, overrun}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
